gshare_branch_predictor: RTL



---
 rtl/gshare_branch_predictor.sv | 111 +++++++++++
 1 files changed

// File: rtl/gshare_branch_predictor.sv
// Gshare/bimodal direction predictor: PHT of saturating counters, speculative GHR
// with mispredict repair from a pipelined snapshot, and saturating statistics.
module gshare_branch_predictor #(
    parameter int PC_W   = 8,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 2,
    parameter int GHR_W  = 6,
    parameter int MODE   = 1,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_valid,
    input  logic              fetch_is_branch,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              prediction,
    output logic [GHR_W-1:0]  pred_ghr,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic [GHR_W-1:0]  upd_ghr,
    input  logic              upd_taken,
    input  logic              upd_mispredict,
    output logic [GHR_W-1:0]  ghr,
    output logic [STAT_W-1:0] lookup_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    if (GHR_W > IDX_W) begin : g_chk_ghr
        $error("GHR_W must not exceed IDX_W");
    end
    if (PC_W < IDX_W) begin : g_chk_pc
        $error("PC_W must be at least IDX_W");
    end
    if (CNT_W < 2 || CNT_W > 4) begin : g_chk_cnt
        $error("CNT_W must be in 2..4");
    end

    logic [CNT_W-1:0]  pht_q [DEPTH];
    logic [GHR_W-1:0]  ghr_q, ghr_d;
    logic [STAT_W-1:0] lookup_q, lookup_d;
    logic [STAT_W-1:0] mispred_q, mispred_d;

    logic [IDX_W-1:0] fhist, uhist, fidx, uidx;
    logic [CNT_W-1:0] cnt_cur, cnt_nxt;
    logic             repair, fetch_br;

    // Update index uses the snapshot that travelled with the branch, never the live GHR.
    assign fhist = (MODE != 0) ? IDX_W'(ghr_q)   : '0;
    assign uhist = (MODE != 0) ? IDX_W'(upd_ghr) : '0;
    assign fidx  = fetch_pc[IDX_W-1:0] ^ fhist;
    assign uidx  = upd_pc[IDX_W-1:0] ^ uhist;

    assign prediction = pht_q[fidx][CNT_W-1];
    assign pred_ghr   = ghr_q;
    assign ghr        = ghr_q;
    assign lookup_cnt  = lookup_q;
    assign mispred_cnt = mispred_q;

    assign repair   = upd_valid & upd_mispredict;
    assign fetch_br = fetch_valid & fetch_is_branch;

    always_comb begin
        cnt_cur = pht_q[uidx];
        cnt_nxt = cnt_cur;
        if (upd_taken) begin
            if (cnt_cur != CNT_MAX) cnt_nxt = cnt_cur + 1'b1;
        end else begin
            if (cnt_cur != '0) cnt_nxt = cnt_cur - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) pht_q[i] <= CNT_INIT;
        end else if (upd_valid) begin
            pht_q[uidx] <= cnt_nxt;
        end
    end

    // A repair wins over a same-cycle fetch shift: that fetch is on the wrong path.
    always_comb begin
        ghr_d     = ghr_q;
        lookup_d  = lookup_q;
        mispred_d = mispred_q;
        if (repair) begin
            ghr_d = {upd_ghr[GHR_W-2:0], upd_taken};
            if (mispred_q != STAT_MAX) mispred_d = mispred_q + 1'b1;
        end else if (fetch_br) begin
            ghr_d = {ghr_q[GHR_W-2:0], prediction};
            if (lookup_q != STAT_MAX) lookup_d = lookup_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q     <= '0;
            lookup_q  <= '0;
            mispred_q <= '0;
        end else begin
            ghr_q     <= ghr_d;
            lookup_q  <= lookup_d;
            mispred_q <= mispred_d;
        end
    end

endmodule
